intro_qsys_button_pio: RTL and testbench

//  Avalon-MM slave input PIO, the read-side counterpart of the LED output PIO.

---
 rtl/intro_qsys_pio_pkg.sv | 32 +++
 rtl/intro_qsys_bit_debounce.sv | 56 +++++
 rtl/intro_qsys_button_pio.sv | 117 +++++++++++
 tb/tb_intro_qsys_button_pio.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/intro_qsys_pio_pkg.sv
// ---------------------------------------------------------------------------
// intro_qsys_pio_pkg
//  Shared definitions for the Avalon-MM input PIO: register word addresses,
//  the edge-selection encoding, and a helper that evaluates one bit's edge.
// ---------------------------------------------------------------------------
package intro_qsys_pio_pkg;

   // Word addresses on the slave port (address 1 is unused and reads 0)
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   // Which transition of the debounced level is captured
   typedef enum logic [1:0] {
      EDGE_RISING  = 2'd0,
      EDGE_FALLING = 2'd1,
      EDGE_ANY     = 2'd2
   } edge_sel_e;

   // Edge detection for one bit, given its current and one-cycle-old level
   function automatic logic edge_hit(input logic cur, input logic prev,
                                     input edge_sel_e sel);
      logic hit;
      case (sel)
         EDGE_RISING:  hit = cur & ~prev;
         EDGE_FALLING: hit = ~cur & prev;
         default:      hit = cur ^ prev;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/intro_qsys_bit_debounce.sv
// ---------------------------------------------------------------------------
// intro_qsys_bit_debounce
//  One input bit: two-flop synchronizer followed by a stability counter.
//  The debounced level only follows the synchronized input after it has
//  differed from the current debounced level for DEBOUNCE_CYC consecutive
//  cycles; any return to the old level restarts the count.
// Ports
//  clk     in   system clock
//  reset   in   asynchronous, active-high reset
//  in_bit  in   asynchronous external input bit
//  deb     out  debounced level (registered)
// ---------------------------------------------------------------------------
module intro_qsys_bit_debounce #(
   parameter int   DEBOUNCE_CYC = 50000,
   parameter logic RESET_BIT    = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic in_bit,
   output logic deb
);

   // Wide enough to hold DEBOUNCE_CYC; the count never reaches it, so no wrap
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   // Synchronizer pair; preset to the idle level so nothing moves after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= RESET_BIT;
         s2 <= RESET_BIT;
      end else begin
         s1 <= in_bit;
         s2 <= s1;
      end
   end

   // Stability counter: counts cycles of disagreement, commits at terminal count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         deb <= RESET_BIT;
      end else if (s2 == deb) begin
         cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
         deb <= s2;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/intro_qsys_button_pio.sv
// ---------------------------------------------------------------------------
// intro_qsys_button_pio
//  Avalon-MM input PIO for board keys/switches. Each bit is synchronized and
//  debounced; the debounced level, a sticky edge-capture register and an
//  interrupt mask are exposed to the processor. Zero wait states, read
//  latency 0 (readdata is a combinational mux).
// Ports
//  clk         in   system clock
//  reset       in   asynchronous, active-high reset
//  address     in   word address: 0 data, 2 irqmask, 3 edgecapture, 1 reads 0
//  chipselect  in   slave select
//  write_n     in   active-low write strobe, qualified by chipselect
//  writedata   in   write data (bits above WIDTH ignored)
//  readdata    out  selected register, zero-extended
//  in_port     in   asynchronous external inputs
//  irq         out  level interrupt, |(edgecapture & irqmask)
// ---------------------------------------------------------------------------
module intro_qsys_button_pio
   import intro_qsys_pio_pkg::*;
#(
   parameter int               WIDTH        = 4,
   parameter int               DEBOUNCE_CYC = 50000,
   parameter int               EDGE_TYPE    = 1,
   parameter logic [WIDTH-1:0] RESET_LEVEL  = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam edge_sel_e EDGE_SEL = edge_sel_e'(EDGE_TYPE[1:0]);

   logic [WIDTH-1:0] debounced;
   logic [WIDTH-1:0] deb_q;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecapture;
   logic [WIDTH-1:0] cap_clear;
   logic             wr_en;

   // Only the low WIDTH bits of writedata carry meaning
   logic unused_writedata;
   assign unused_writedata = ^writedata;

   assign wr_en = chipselect & ~write_n;

   // Per-bit synchronizer/debouncer and edge detector
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      intro_qsys_bit_debounce #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .RESET_BIT    (RESET_LEVEL[i])
      ) u_debounce (
         .clk    (clk),
         .reset  (reset),
         .in_bit (in_port[i]),
         .deb    (debounced[i])
      );

      assign edge_det[i] = edge_hit(debounced[i], deb_q[i], EDGE_SEL);
   end

   // Write-1-to-clear mask for the edge-capture register
   always_comb begin
      cap_clear = '0;
      if (wr_en && (address == ADDR_EDGECAP)) begin
         cap_clear = writedata[WIDTH-1:0];
      end
   end

   // Delayed level for edge detection; preset to the idle level so reset
   // never looks like an edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb_q <= RESET_LEVEL;
      end else begin
         deb_q <= debounced;
      end
   end

   // Interrupt mask register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irqmask <= '0;
      end else if (wr_en && (address == ADDR_IRQMASK)) begin
         irqmask <= writedata[WIDTH-1:0];
      end
   end

   // Sticky edge capture; a new edge overrides a clear in the same cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edgecapture <= '0;
      end else begin
         edgecapture <= (edgecapture & ~cap_clear) | edge_det;
      end
   end

   // Combinational read mux, zero-extended to 32 bits
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:    readdata[WIDTH-1:0] = debounced;
         ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
         ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecapture;
         default:      readdata = '0;
      endcase
   end

   assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_intro_qsys_button_pio.sv
// ---------------------------------------------------------------------------
// tb_intro_qsys_button_pio
//  Directed scenarios followed by randomized input/bus activity, compared
//  against a window-based behavioural model of the PIO.
// ---------------------------------------------------------------------------
module tb_intro_qsys_button_pio;

   localparam int         WIDTH     = 4;
   localparam int         DEB       = 4;
   localparam int         EDGE_TYPE = 1;
   localparam logic [3:0] RL        = 4'hF;

   logic        clk        = 1'b0;
   logic        reset      = 1'b0;
   logic [1:0]  address    = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n    = 1'b1;
   logic [31:0] writedata  = 32'd0;
   logic [31:0] readdata;
   logic [3:0]  in_port    = 4'hF;
   logic        irq;

   int total = 0;
   int bad   = 0;

   intro_qsys_button_pio #(
      .WIDTH        (WIDTH),
      .DEBOUNCE_CYC (DEB),
      .EDGE_TYPE    (EDGE_TYPE),
      .RESET_LEVEL  (RL)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   always #10 clk = ~clk;

   // Reference model: the input reaches the debounce stage two clocks late;
   // a bit's debounced level flips once the last DEB observed samples all
   // disagree with it. Falling edges of that level are captured.
   logic [3:0] m_s1, m_s2, m_deb, m_debq, m_cap, m_mask;
   logic [3:0] m_win[$];

   task automatic model_step();
      logic [3:0] nxt_deb;
      logic [3:0] edges;
      logic [3:0] clr;
      logic       all_flip;
      if (reset) begin
         m_s1 = RL; m_s2 = RL; m_deb = RL; m_debq = RL;
         m_cap = 4'h0; m_mask = 4'h0;
         m_win.delete();
         return;
      end
      m_win.push_back(m_s2);
      if (m_win.size() > DEB) void'(m_win.pop_front());
      nxt_deb = m_deb;
      if (m_win.size() == DEB) begin
         for (int b = 0; b < 4; b++) begin
            all_flip = 1'b1;
            foreach (m_win[k]) if (m_win[k][b] == m_deb[b]) all_flip = 1'b0;
            if (all_flip) nxt_deb[b] = ~m_deb[b];
         end
      end
      edges = m_debq & ~m_deb;
      clr   = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
      m_cap  = (m_cap & ~clr) | edges;
      m_debq = m_deb;
      m_deb  = nxt_deb;
      m_s2   = m_s1;
      m_s1   = in_port;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         model_step();
      end
   end

   function automatic logic [31:0] model_rd(input logic [1:0] a);
      case (a)
         2'd0:    return {28'd0, m_deb};
         2'd2:    return {28'd0, m_mask};
         2'd3:    return {28'd0, m_cap};
         default: return 32'd0;
      endcase
   endfunction

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic [3:0] v);
      in_port = v;
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] obs);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      obs = readdata;
   endtask

   // Drives the write now, holds it across one rising edge, releases at negedge
   task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic check_all(input string tag);
      logic [31:0] obs;
      for (int a = 0; a < 4; a++) begin
         read_reg(2'(a), obs);
         check_output($sformatf("%s/rd%0d", tag, a), obs, model_rd(2'(a)));
      end
      check_output({tag, "/irq"}, {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
   endtask

   task automatic check_const(input string tag, input logic [1:0] a,
                              input logic [31:0] expected);
      logic [31:0] obs;
      read_reg(a, obs);
      check_output(tag, obs, expected);
   endtask

   initial begin
      logic [31:0] r;
      int          hold;

      // 1: reset, idle-high inputs
      #1 reset = 1'b1;
      apply_stimulus(4'hF);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      $display("[TB] step 1: reset state");
      check_all("s1");
      check_const("s1_data", 2'd0, 32'hF);
      check_const("s1_cap", 2'd3, 32'h0);
      check_const("s1_addr1", 2'd1, 32'h0);
      check_output("s1_irq", {31'd0, irq}, 32'd0);

      // 2: bit0 falls; debounced data changes exactly 6 clocks later
      $display("[TB] step 2: debounce latency");
      @(negedge clk);
      apply_stimulus(4'hE);
      repeat (5) begin
         @(negedge clk);
         check_all("s2_wait");
      end
      check_const("s2_before6", 2'd0, 32'hF);
      @(negedge clk);
      check_const("s2_at6", 2'd0, 32'hE);
      @(negedge clk);
      check_const("s2_cap", 2'd3, 32'h1);
      check_output("s2_irq", {31'd0, irq}, 32'd0);
      check_all("s2");

      // 3: masked interrupt, then write-1-to-clear
      $display("[TB] step 3: irq and clear");
      write_reg(2'd3, 32'h1);
      write_reg(2'd2, 32'h1);
      check_const("s3_mask", 2'd2, 32'h1);
      apply_stimulus(4'hF);
      repeat (10) @(negedge clk);
      check_all("s3_rise");
      check_output("s3_rise_irq", {31'd0, irq}, 32'd0);
      apply_stimulus(4'hE);
      repeat (6) @(negedge clk);
      check_const("s3_precap", 2'd3, 32'h0);
      @(negedge clk);
      check_const("s3_cap", 2'd3, 32'h1);
      check_output("s3_irq_on", {31'd0, irq}, 32'd1);
      write_reg(2'd3, 32'h1);
      check_const("s3_cleared", 2'd3, 32'h0);
      check_output("s3_irq_off", {31'd0, irq}, 32'd0);

      // 4: 3-cycle glitch on bit1 is rejected
      $display("[TB] step 4: glitch");
      apply_stimulus(4'hC);
      repeat (3) @(negedge clk);
      apply_stimulus(4'hE);
      repeat (10) begin
         @(negedge clk);
         check_all("s4");
      end
      check_const("s4_data", 2'd0, 32'hE);
      check_const("s4_cap", 2'd3, 32'h0);

      // 5: clear on bit2 in the same cycle as its edge: edge wins
      $display("[TB] step 5: edge vs clear");
      apply_stimulus(4'hA);
      repeat (6) @(negedge clk);
      write_reg(2'd3, 32'h4);
      check_const("s5_cap", 2'd3, 32'h4);
      check_all("s5");

      // 6: reset with pending edges and mid-debounce activity
      $display("[TB] step 6: reset with pending state");
      write_reg(2'd3, 32'hF);
      write_reg(2'd2, 32'h3);
      apply_stimulus(4'hF);
      repeat (10) @(negedge clk);
      apply_stimulus(4'hC);
      repeat (8) @(negedge clk);
      check_const("s6_cap", 2'd3, 32'h3);
      check_output("s6_irq_on", {31'd0, irq}, 32'd1);
      apply_stimulus(4'h0);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_output("s6_irq_reset", {31'd0, irq}, 32'd0);
      check_const("s6_cap_reset", 2'd3, 32'h0);
      apply_stimulus(4'hF);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (20) begin
         @(negedge clk);
         check_all("s6_post");
      end
      check_const("s6_data", 2'd0, 32'hF);
      check_const("s6_mask", 2'd2, 32'h0);
      check_const("s6_cap_post", 2'd3, 32'h0);
      check_output("s6_irq_post", {31'd0, irq}, 32'd0);

      // Randomized inputs with random hold times and occasional bus writes
      $display("[TB] random phase");
      for (int n = 0; n < 80; n++) begin
         r    = $urandom;
         hold = $urandom_range(1, 8);
         apply_stimulus(r[3:0]);
         for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check_all("rand");
            if ($urandom_range(0, 7) == 0) begin
               r = $urandom;
               write_reg(r[5:4], $urandom);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
